// File: rtl/cpu_pkg.sv
// Shared CPU types: pipeline hazard FSM states,
// EX-stage register write codes and register address width.
package cpu_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [2:0] {
    RUN,
    LD_STALL,
    BR_STALL,
    MULDIV,
    HALT
  } state_t;

  localparam logic [1:0] RW_NONE   = 2'b00;
  localparam logic [1:0] RW_OP1_R0 = 2'b10;
  localparam logic [1:0] RW_OP1    = 2'b11;

endpackage

// File: rtl/hazard_compare.sv
// Register dependency comparators between the ID and EX stages.
// Flags load-use and branch-operand hazards that bypassing cannot cover.
module hazard_compare #(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] id_op1,
  input  logic [REG_AW-1:0] id_op2,
  input  logic              id_uses_op2,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] ex_op1,
  input  logic [1:0]        ex_regwrite,
  input  logic              ex_memread,
  output logic              load_use,
  output logic              br_dep
);
  import cpu_pkg::*;

  logic ex_wr;
  logic r0_wr;
  logic hit1;
  logic hit2;

  // mul/div also writes R0, so R0 readers depend on it
  assign ex_wr = (ex_regwrite == RW_OP1) || (ex_regwrite == RW_OP1_R0);
  assign r0_wr = (ex_regwrite == RW_OP1_R0);

  assign hit1 = (ex_wr && ex_op1 == id_op1) || (r0_wr && id_op1 == '0);
  assign hit2 = (ex_wr && ex_op1 == id_op2) || (r0_wr && id_op2 == '0);

  assign load_use = ex_memread && (hit1 || (id_uses_op2 && hit2));

  // branch compares in ID, so even an ALU result is too late
  assign br_dep = id_branch && hit1 && !ex_memread;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: freezes and bubbles PC, IF/ID, ID/EX
// and EX/MEM for load-use, branch-operand, mul/div, flush and halt.
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 4,
  parameter int REG_AW     = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_op1,
  input  logic [REG_AW-1:0] id_op2,
  input  logic              id_uses_op2,
  input  logic              id_branch,
  input  logic              id_branch_taken,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_op1,
  input  logic [1:0]        ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_muldiv,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_we,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              muldiv_busy,
  output logic              halted
);
  import cpu_pkg::*;

  if (MULDIV_LAT < 2 || MULDIV_LAT > 15) begin : g_bad_lat
    $error("hazard_stall_unit: MULDIV_LAT must be in 2..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);

  state_t     state;
  state_t     state_d;
  logic [3:0] count;
  logic [3:0] count_d;
  logic       load_use;
  logic       br_dep;

  hazard_compare #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .id_op1      (id_op1),
    .id_op2      (id_op2),
    .id_uses_op2 (id_uses_op2),
    .id_branch   (id_branch),
    .ex_op1      (ex_op1),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .load_use    (load_use),
    .br_dep      (br_dep)
  );

  // decode controls and next state; reset forces the idle RUN decode
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_busy  = 1'b0;
    halted       = 1'b0;
    state_d      = state;
    count_d      = count;
    if (!rst) begin
      unique case (state)
        RUN, LD_STALL: begin
          state_d = RUN;
          if (ex_muldiv) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
            muldiv_busy  = 1'b1;
            state_d      = MULDIV;
            count_d      = CNT_INIT;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = id_branch ? BR_STALL : LD_STALL;
          end else if (br_dep) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_halt) begin
            state_d = HALT;
          end else begin
            ifid_flush = id_branch_taken;
          end
        end
        BR_STALL: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = RUN;
        end
        MULDIV: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          muldiv_busy  = 1'b1;
          count_d      = count - 4'd1;
          if (count == 4'd1) begin
            state_d = RUN;
          end
        end
        HALT: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          state_d = RUN;
          count_d = '0;
        end
      endcase
    end
  end

  // state and mul/div occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit with an
// expected-output scoreboard queue.
module tb_hazard_stall_unit;
  import cpu_pkg::*;

  localparam int LAT = 4;

  // out vector: pc_we ifid_we ifid_flush idex_we idex_bubble exmem_bubble muldiv_busy halted
  localparam logic [7:0] RUNV  = 8'b1101_0000;
  localparam logic [7:0] STALL = 8'b0001_1000;
  localparam logic [7:0] MD    = 8'b0000_0110;
  localparam logic [7:0] FLUSH = 8'b1111_0000;
  localparam logic [7:0] HALTV = 8'b0001_1001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_op1, id_op2, ex_op1;
  logic       id_uses_op2, id_branch, id_branch_taken, id_halt;
  logic [1:0] ex_regwrite;
  logic       ex_memread, ex_muldiv;
  logic       pc_we, ifid_we, ifid_flush, idex_we;
  logic       idex_bubble, exmem_bubble, muldiv_busy, halted;
  logic [7:0] outv;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_LAT(LAT), .REG_AW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_op1          (id_op1),
    .id_op2          (id_op2),
    .id_uses_op2     (id_uses_op2),
    .id_branch       (id_branch),
    .id_branch_taken (id_branch_taken),
    .id_halt         (id_halt),
    .ex_op1          (ex_op1),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_muldiv       (ex_muldiv),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_we         (idex_we),
    .idex_bubble     (idex_bubble),
    .exmem_bubble    (exmem_bubble),
    .muldiv_busy     (muldiv_busy),
    .halted          (halted)
  );

  assign outv = {pc_we, ifid_we, ifid_flush, idex_we,
                 idex_bubble, exmem_bubble, muldiv_busy, halted};

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_op1 = 4'd1; id_op2 = 4'd2; ex_op1 = 4'd14;
    id_uses_op2 = 1'b0; id_branch = 1'b0;
    id_branch_taken = 1'b0; id_halt = 1'b0;
    ex_regwrite = RW_NONE; ex_memread = 1'b0; ex_muldiv = 1'b0;
  endtask

  // push expectation, compare at negedge, advance to next drive point
  task automatic cyc(input string tag, input logic [7:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), outv, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    ex_muldiv = 1'b1; ex_memread = 1'b1; id_halt = 1'b1;
    id_branch_taken = 1'b1;
    cyc("rst_mask", RUNV);
    clr();
    rst = 1'b0;
    cyc("idle", RUNV);

    // load-use through op2
    ex_memread = 1'b1; ex_regwrite = RW_OP1; ex_op1 = 4'd5;
    id_op2 = 4'd5; id_uses_op2 = 1'b1;
    cyc("ld_use", STALL);
    ex_memread = 1'b0; ex_regwrite = RW_NONE;
    cyc("ld_use_rel", RUNV);
    clr();

    // op2 not read: no stall
    ex_memread = 1'b1; ex_regwrite = RW_OP1; ex_op1 = 4'd5;
    id_op2 = 4'd5; id_op1 = 4'd2;
    cyc("no_op2", RUNV);
    clr();

    // load feeding a branch: two bubbles, flush masked
    ex_memread = 1'b1; ex_regwrite = RW_OP1; ex_op1 = 4'd3;
    id_branch = 1'b1; id_op1 = 4'd3; id_branch_taken = 1'b1;
    cyc("ld_br1", STALL);
    ex_memread = 1'b0; ex_regwrite = RW_NONE;
    cyc("ld_br2", STALL);
    cyc("ld_br_flush", FLUSH);
    clr();
    cyc("ld_br_after", RUNV);

    // ALU result feeding a branch
    ex_regwrite = RW_OP1; ex_op1 = 4'd7;
    id_branch = 1'b1; id_op1 = 4'd7; id_branch_taken = 1'b1;
    cyc("br_dep", STALL);
    ex_regwrite = RW_NONE;
    cyc("br_dep_flush", FLUSH);
    clr();

    // write code 01 writes nothing
    ex_regwrite = 2'b01; ex_op1 = 4'd7;
    id_branch = 1'b1; id_op1 = 4'd7;
    cyc("rw01", RUNV);
    clr();

    // mul/div occupies EX for LAT cycles, branch held
    ex_muldiv = 1'b1; id_branch_taken = 1'b1; id_branch = 1'b1;
    cyc("md_entry", MD);
    ex_muldiv = 1'b0;
    for (int i = 1; i < LAT; i++) cyc("md_busy", MD);
    clr();
    ex_regwrite = RW_OP1_R0; ex_op1 = 4'd9;
    id_branch = 1'b1; id_op1 = 4'd0;
    cyc("r0_dep", STALL);
    clr();
    cyc("md_after", RUNV);

    // taken branch, no hazard
    id_branch = 1'b1; id_branch_taken = 1'b1;
    cyc("flush", FLUSH);
    clr();
    cyc("flush_once", RUNV);

    // reset while mid mul/div
    ex_muldiv = 1'b1;
    cyc("md2_entry", MD);
    clr();
    cyc("md2_busy", MD);
    rst = 1'b1;
    cyc("md2_rst", RUNV);
    rst = 1'b0;
    ex_muldiv = 1'b1;
    cyc("md3_entry", MD);
    clr();
    for (int i = 1; i < LAT; i++) cyc("md3_busy", MD);
    cyc("md3_done", RUNV);

    // halt outranks flush, then sticks until reset
    id_halt = 1'b1; id_branch = 1'b1; id_branch_taken = 1'b1;
    cyc("halt_seen", RUNV);
    clr();
    ex_muldiv = 1'b1; id_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc("halted", HALTV);
    clr();
    rst = 1'b1;
    cyc("halt_rst", RUNV);
    rst = 1'b0;
    cyc("post_rst", RUNV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hazard controller for the 16-register, 4-stage-plus-WB CPU. It handles the hazards that bypassing cannot resolve: load-use, branch-operand-not-ready, multi-cycle multiply/divide occupancy, taken-branch flush and halt. The forwarding logic selects bypass data; this block freezes and bubbles the pipeline whenever no bypass path exists yet. It drives the write enables and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM.

Parameters:
MULDIV_LAT, 4, total EX cycles occupied by a multiply or divide (range 2..15)
REG_AW, 4, register address width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
id_op1  input  REG_AW  ID-stage source/dest register 1
id_op2  input  REG_AW  ID-stage source register 2
id_uses_op2  input  1  ID instruction reads op2
id_branch  input  1  ID instruction is a branch comparing id_op1
id_branch_taken  input  1  branch resolved taken in ID (valid only when not stalled)
id_halt  input  1  ID instruction is HALT
ex_op1  input  REG_AW  EX-stage destination register
ex_regwrite  input  2  EX write code: 2'b11 writes op1; 2'b10 writes op1 and R0 (mul/div); others none
ex_memread  input  1  EX instruction is a load
ex_muldiv  input  1  EX instruction is multiply/divide (first EX cycle)
pc_we  output  1  PC write enable
ifid_we  output  1  IF/ID write enable
ifid_flush  output  1  zero IF/ID on the next edge
idex_we  output  1  ID/EX write enable
idex_bubble  output  1  load NOP into ID/EX
exmem_bubble  output  1  load NOP into EX/MEM
muldiv_busy  output  1  multiply/divide in progress
halted  output  1  processor halted

Behaviour:
- State reg: RUN, LD_STALL, BR_STALL, MULDIV, HALT. Reset (async): state=RUN, count=0. Outputs are combinational from state and inputs. With reset asserted the outputs decode as RUN with all hazard inputs low: pc_we=1, ifid_we=1, idex_we=1, all others 0.
- ex_wr = ex_regwrite==2'b11 or ex_regwrite==2'b10. hit(r) = ex_wr and ex_op1==r, or ex_regwrite==2'b10 and r==0.
- Load-use (RUN): ex_memread and (hit(id_op1) or id_uses_op2 and hit(id_op2)). Response this cycle: pc_we=0, ifid_we=0, idex_bubble=1. Next state LD_STALL, or BR_STALL if id_branch (load feeding a branch needs 2 bubbles).
- Branch-operand (RUN, no load-use): id_branch and hit(id_op1) and not ex_memread. Response: same freeze plus bubble for 1 cycle, next state RUN. In BR_STALL, freeze plus bubble for one more cycle, then RUN.
- LD_STALL: outputs as RUN. It re-evaluates hazards in the same cycle, which is legal back-to-back. Next state RUN unless a new hazard is detected.
- Mul/div (RUN, ex_muldiv=1): enter MULDIV with count=MULDIV_LAT-1. In MULDIV: pc_we=ifid_we=idex_we=0, exmem_bubble=1, muldiv_busy=1, count decrements each cycle. When count==1, next state RUN. EX is thus occupied exactly MULDIV_LAT cycles and the result reaches EX/MEM on the last one. In the entry cycle muldiv_busy=1 and the freeze applies.
- Taken branch: ifid_flush=1 only in RUN, only when no stall is asserted that cycle, and only when id_branch_taken=1. It is never asserted during a stall, because the branch is re-evaluated.
- HALT: when id_halt is seen in RUN with no stall, the state goes to HALT on the next edge. In HALT, pc_we=ifid_we=0, idex_bubble=1, halted=1. Only rst leaves HALT.
- Priority when events coincide in RUN: muldiv > load-use > branch-operand > halt > flush. A halt or branch in ID behind a muldiv is held and re-evaluated after RUN resumes.
- Reset mid-stall or mid-muldiv: immediate return to RUN with count=0. No residual bubble.
- count width is 4 bits. MULDIV_LAT outside 2..15 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- cpu_pkg: state enum (RUN, LD_STALL, BR_STALL, MULDIV, HALT), regwrite codes (RW_NONE=2'b00, RW_OP1_R0=2'b10, RW_OP1=2'b11), REG_AW.
- The hazard-detect comparators go in one combinational sub-module, hazard_compare (outputs load_use, br_dep). The FSM and counter stay in hazard_stall_unit.

Test Plan:
- Load-use: ex_memread=1, ex_regwrite=11, ex_op1=5, id_op2=5, id_uses_op2=1 -> one cycle with pc_we=0, ifid_we=0, idex_bubble=1; next cycle pc_we=1.
- Load then branch: ex_memread=1, ex_op1=3, id_branch=1, id_op1=3 -> two consecutive bubble cycles, ifid_flush=0 throughout; flush allowed on cycle 3 if id_branch_taken=1.
- Mul/div with MULDIV_LAT=4: ex_muldiv pulse -> muldiv_busy=1 and exmem_bubble=1 for exactly 4 cycles, then pc_we=1; ex_regwrite=10 with id_op1=0 on resume -> R0 dependency stall.
- Taken branch, no hazard: id_branch=1, id_branch_taken=1, ex_regwrite=00 -> ifid_flush=1 for 1 cycle, pc_we=1.
- Halt: id_halt=1 -> halted=1 from the next cycle, pc_we=0 indefinitely; rst pulse -> halted=0, pc_we=1 immediately (async).
- Reset during MULDIV (count=2) -> outputs return to RUN values asynchronously; a fresh ex_muldiv afterwards gives a full MULDIV_LAT occupancy.
